// File: rtl/tipi_reg_bridge.sv
// rtl/tipi_reg_bridge.sv - TI-99/4A <-> Raspberry Pi register bridge for the TIPI FPGA
// TI writes land in wreg and raise a flag for the RPi; RPi shifts bytes into rreg for the TI.
module tipi_reg_bridge #(
  parameter int          CH          = 2,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] TOP_ADDR    = 16'h5FFF,
  localparam int         SELW        = $clog2(2 * CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cru_dsr_en,
  input  logic [15:0]     ti_a,
  input  logic [7:0]      ti_data,
  input  logic            ti_memen,
  input  logic            ti_we,
  input  logic            ti_dbin,
  output logic [7:0]      dsr_d,
  output logic            tipi_dbus_oe,
  output logic            dsr_rom_sel,
  input  logic            rpi_sclk,
  input  logic [SELW-1:0] rpi_regsel,
  input  logic            rpi_sdata_out,
  input  logic            rpi_sle,
  output logic            rpi_sdata_in,
  output logic            rpi_irq
);

  localparam int            SW       = 29 + SELW;
  localparam logic [SW-1:0] SYNC_RST = {2'b11, {(SW - 2){1'b0}}};
  localparam logic [15:0]   ROM_LO   = 16'h4000;
  localparam logic [15:0]   ROM_HI   = 16'(int'(TOP_ADDR) - 2 * (2 * CH - 1)) & 16'hFFFE;

  // TI bit 0 is the MSB, so TI A0 is ti_a[15] here and address values compare directly.
  function automatic logic [15:0] wr_addr(input int k);
    return 16'(int'(TOP_ADDR) - 2 * k);
  endfunction

  function automatic logic [15:0] rd_addr(input int k);
    return 16'(int'(TOP_ADDR) - 2 * (CH + k));
  endfunction

  logic [SW-1:0]   sync_pipe [SYNC_STAGES];
  logic            we_s, memen_s, sclk_s, sle_s, sdata_s;
  logic [SELW-1:0] sel_s;
  logic [15:0]     a_s;
  logic [7:0]      data_s;

  // Strobes reset to their idle levels so the pipeline never fakes a bus cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_pipe[s] <= SYNC_RST;
    end else begin
      sync_pipe[0] <= {ti_we, ti_memen, rpi_sclk, rpi_sle, rpi_sdata_out, rpi_regsel, ti_a, ti_data};
      for (int s = 1; s < SYNC_STAGES; s++) sync_pipe[s] <= sync_pipe[s-1];
    end
  end

  assign {we_s, memen_s, sclk_s, sle_s, sdata_s, sel_s, a_s, data_s} = sync_pipe[SYNC_STAGES-1];

  logic [7:0]    wreg    [CH];
  logic [7:0]    hold    [CH];
  logic [7:0]    rreg    [CH];
  logic [7:0]    pdata   [CH];
  logic [7:0]    shreg_r [CH];
  logic [7:0]    shreg_w [CH];
  logic [CH-1:0] hvalid, flag, pend, rd_hit;
  logic          we_d, sclk_d, sle_d, sdo_next;
  logic          we_rise, sclk_rise, sle_rise, wr_ok, ti_rd;

  assign we_rise   = we_s & ~we_d;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sle_rise  = sle_s & ~sle_d;
  assign wr_ok     = cru_dsr_en & ~we_s & ~memen_s;
  assign ti_rd     = cru_dsr_en & ~ti_memen & ti_dbin;

  // Read decode works on the raw bus: the TI samples data long before a synced strobe would arrive.
  always_comb begin
    rd_hit = '0;
    for (int k = 0; k < CH; k++) rd_hit[k] = ti_rd && (ti_a == rd_addr(k));
  end

  assign dsr_rom_sel  = ti_rd && (ti_a >= ROM_LO) && (ti_a < ROM_HI);
  assign tipi_dbus_oe = ~((|rd_hit) | dsr_rom_sel);

  always_comb begin
    dsr_d = '0;
    for (int k = 0; k < CH; k++) begin
      if (rd_hit[k]) dsr_d = rreg[k];
    end
  end

  always_comb begin
    sdo_next = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (sel_s == SELW'(k))      sdo_next = shreg_r[k][7];
      if (sel_s == SELW'(CH + k)) sdo_next = shreg_w[k][7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) begin
        wreg[k]    <= '0;
        hold[k]    <= '0;
        rreg[k]    <= '0;
        pdata[k]   <= '0;
        shreg_r[k] <= '0;
        shreg_w[k] <= '0;
      end
      hvalid       <= '0;
      flag         <= '0;
      pend         <= '0;
      we_d         <= 1'b1;
      sclk_d       <= 1'b0;
      sle_d        <= 1'b0;
      rpi_sdata_in <= 1'b0;
      rpi_irq      <= 1'b0;
    end else begin
      we_d         <= we_s;
      sclk_d       <= sclk_s;
      sle_d        <= sle_s;
      rpi_sdata_in <= sdo_next;
      rpi_irq      <= |flag;
      for (int k = 0; k < CH; k++) begin
        if (wr_ok && a_s == wr_addr(k)) begin
          hold[k]   <= data_s;
          hvalid[k] <= 1'b1;
        end
        if (sel_s == SELW'(CH + k)) begin
          if (sle_rise) begin
            shreg_w[k] <= wreg[k];
            flag[k]    <= 1'b0;
          end else if (sclk_rise) begin
            shreg_w[k] <= {shreg_w[k][6:0], 1'b0};
          end
        end
        // Placed after the RPi clear so a commit in the same cycle keeps the flag set.
        if (we_rise && hvalid[k]) begin
          wreg[k]   <= hold[k];
          flag[k]   <= 1'b1;
          hvalid[k] <= 1'b0;
        end
        if (sclk_rise && !sle_rise && sel_s == SELW'(k))
          shreg_r[k] <= {shreg_r[k][6:0], sdata_s};
        // Never change rreg under an active TI read; park the byte in pdata instead.
        if (sle_rise && sel_s == SELW'(k)) begin
          if (rd_hit[k]) begin
            pend[k]  <= 1'b1;
            pdata[k] <= shreg_r[k];
          end else begin
            rreg[k] <= shreg_r[k];
            pend[k] <= 1'b0;
          end
        end else if (pend[k] && !rd_hit[k]) begin
          rreg[k] <= pdata[k];
          pend[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tipi_reg_bridge.sv
// tb/tb_tipi_reg_bridge.sv - scoreboard bench for tipi_reg_bridge
module tb_tipi_reg_bridge;
  localparam int          CH   = 2;
  localparam int          SELW = 2;
  localparam logic [15:0] TOP  = 16'h5FFF;

  localparam int K_D = 0, K_OE = 1, K_ROM = 2, K_SDO = 3, K_IRQ = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cru_dsr_en = 1'b1;
  logic [15:0]     ti_a = '0;
  logic [7:0]      ti_data = '0;
  logic            ti_memen = 1'b1;
  logic            ti_we = 1'b1;
  logic            ti_dbin = 1'b0;
  logic [7:0]      dsr_d;
  logic            tipi_dbus_oe, dsr_rom_sel, rpi_sdata_in, rpi_irq;
  logic            rpi_sclk = 1'b0;
  logic [SELW-1:0] rpi_regsel = '0;
  logic            rpi_sdata_out = 1'b0;
  logic            rpi_sle = 1'b0;

  tipi_reg_bridge #(.CH(CH), .SYNC_STAGES(2), .TOP_ADDR(TOP)) dut (
    .clk(clk), .rst_n(rst_n), .cru_dsr_en(cru_dsr_en),
    .ti_a(ti_a), .ti_data(ti_data), .ti_memen(ti_memen), .ti_we(ti_we), .ti_dbin(ti_dbin),
    .dsr_d(dsr_d), .tipi_dbus_oe(tipi_dbus_oe), .dsr_rom_sel(dsr_rom_sel),
    .rpi_sclk(rpi_sclk), .rpi_regsel(rpi_regsel), .rpi_sdata_out(rpi_sdata_out),
    .rpi_sle(rpi_sle), .rpi_sdata_in(rpi_sdata_in), .rpi_irq(rpi_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference state: what each register should hold, independent of any pipeline detail.
  logic [7:0]    wreg_m [CH];
  logic [7:0]    rreg_m [CH];
  logic [CH-1:0] flag_m;
  logic [15:0]   wr_tab [CH];
  logic [15:0]   rd_tab [CH];

  function automatic string kname(input int k);
    case (k)
      K_D:     return "dsr_d";
      K_OE:    return "tipi_dbus_oe";
      K_ROM:   return "dsr_rom_sel";
      K_SDO:   return "rpi_sdata_in";
      default: return "rpi_irq";
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_D:     act = dsr_d;
        K_OE:    act = {7'b0, tipi_dbus_oe};
        K_ROM:   act = {7'b0, dsr_rom_sel};
        K_SDO:   act = {7'b0, rpi_sdata_in};
        default: act = {7'b0, rpi_irq};
      endcase
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h at %0t", kname(e.kind), act, e.val, $time);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_timeout: %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic push_irq();
    push(K_IRQ, {7'b0, |flag_m});
  endtask

  task automatic ti_write_begin(input logic [15:0] addr, input logic [7:0] data);
    ti_a     = addr;
    ti_data  = data;
    ti_memen = 1'b0;
    ti_we    = 1'b0;
    step(4);
  endtask

  task automatic model_write(input logic [15:0] addr, input logic [7:0] data);
    if (cru_dsr_en) begin
      for (int k = 0; k < CH; k++) begin
        if (addr == wr_tab[k]) begin
          wreg_m[k] = data;
          flag_m[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic ti_write(input logic [15:0] addr, input logic [7:0] data);
    ti_write_begin(addr, data);
    ti_we    = 1'b1;
    ti_memen = 1'b1;
    model_write(addr, data);
    step(5);
  endtask

  task automatic ti_read_begin(input logic [15:0] addr);
    ti_a     = addr;
    ti_memen = 1'b0;
    ti_dbin  = 1'b1;
    #1;
  endtask

  task automatic ti_read_end();
    ti_memen = 1'b1;
    ti_dbin  = 1'b0;
    step(1);
  endtask

  task automatic ti_read_check(input logic [15:0] addr);
    logic [7:0] d;
    logic       oe, rom;
    d   = 8'h00;
    oe  = 1'b1;
    rom = 1'b0;
    if (cru_dsr_en) begin
      for (int k = 0; k < CH; k++) begin
        if (addr == rd_tab[k]) begin
          d  = rreg_m[k];
          oe = 1'b0;
        end
      end
      if (addr >= 16'h4000 && addr < 16'h5FF8) begin
        rom = 1'b1;
        oe  = 1'b0;
      end
    end
    ti_read_begin(addr);
    push(K_D, d);
    push(K_OE, {7'b0, oe});
    push(K_ROM, {7'b0, rom});
    drain();
    ti_read_end();
  endtask

  task automatic sclk_pulse();
    rpi_sclk = 1'b1;
    step(3);
    rpi_sclk = 1'b0;
    step(3);
  endtask

  task automatic rpi_latch(input int idx);
    rpi_regsel = SELW'(idx);
    step(3);
    rpi_sle = 1'b1;
    step(3);
    rpi_sle = 1'b0;
    step(3);
  endtask

  task automatic rpi_write(input int k, input logic [7:0] val);
    rpi_regsel = SELW'(k);
    step(3);
    for (int j = 0; j < 8; j++) begin
      rpi_sdata_out = val[7-j];
      step(1);
      sclk_pulse();
    end
    rpi_latch(k);
    rreg_m[k] = val;
  endtask

  task automatic shift_out(input logic [7:0] exp_byte);
    for (int j = 0; j < 8; j++) begin
      push(K_SDO, {7'b0, exp_byte[7-j]});
      drain();
      sclk_pulse();
    end
  endtask

  task automatic rpi_read(input int k);
    logic [7:0] b;
    b = wreg_m[k];
    rpi_latch(CH + k);
    flag_m[k] = 1'b0;
    push_irq();
    drain();
    shift_out(b);
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      wreg_m[k] = '0;
      rreg_m[k] = '0;
    end
    flag_m = '0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  old;
    logic [15:0] addr_list [10];
    int          op, r;
    wr_tab[0] = 16'h5FFF; wr_tab[1] = 16'h5FFD;
    rd_tab[0] = 16'h5FFB; rd_tab[1] = 16'h5FF9;
    addr_list[0] = 16'h5FFF; addr_list[1] = 16'h5FFD; addr_list[2] = 16'h5FFB;
    addr_list[3] = 16'h5FF9; addr_list[4] = 16'h5FF7; addr_list[5] = 16'h5FF8;
    addr_list[6] = 16'h4000; addr_list[7] = 16'h3FFF; addr_list[8] = 16'h6000;
    addr_list[9] = 16'h5FFA;
    model_reset();

    step(2);
    push(K_SDO, 8'h00);
    push(K_IRQ, 8'h00);
    drain();
    rst_n = 1'b1;
    step(3);
    ti_read_check(16'h5FFB);
    ti_read_check(16'h5FF9);

    ti_write(16'h5FFF, 8'hA5);
    push_irq();
    drain();
    rpi_read(0);

    rpi_write(1, 8'h3C);
    ti_read_check(16'h5FF9);
    ti_read_check(16'h5FFB);

    // RPi latch while the TI is mid-read: the bus must keep the old byte.
    rpi_write(0, 8'h11);
    ti_read_begin(16'h5FFB);
    rpi_write(0, 8'h77);
    push(K_D, 8'h11);
    push(K_OE, 8'h00);
    drain();
    ti_read_end();
    step(2);
    ti_read_check(16'h5FFB);

    // TI commit and RPi load of the same register in one cycle.
    ti_write(16'h5FFD, 8'h99);
    rpi_regsel = SELW'(CH + 1);
    ti_write_begin(16'h5FFD, 8'h42);
    old      = wreg_m[1];
    ti_we    = 1'b1;
    ti_memen = 1'b1;
    rpi_sle  = 1'b1;
    wreg_m[1] = 8'h42;
    flag_m[1] = 1'b1;
    step(3);
    rpi_sle = 1'b0;
    step(3);
    push_irq();
    drain();
    shift_out(old);
    rpi_read(1);

    ti_read_check(16'h4000);
    ti_read_check(16'h5FF7);
    ti_read_check(16'h5FF8);
    cru_dsr_en = 1'b0;
    ti_read_check(16'h4000);
    ti_read_check(16'h5FF7);
    ti_read_check(16'h5FFB);
    ti_write(16'h5FFF, 8'hEE);
    cru_dsr_en = 1'b1;
    ti_read_check(16'h5FF9);

    for (int it = 0; it < 40; it++) begin
      cru_dsr_en = ($urandom_range(0, 4) != 0);
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          r = $urandom_range(0, 3);
          if (r < 2)       ti_write(wr_tab[r], 8'($urandom));
          else if (r == 2) ti_write(rd_tab[$urandom_range(0, CH - 1)], 8'($urandom));
          else             ti_write(16'h5F00, 8'($urandom));
          push_irq();
          drain();
        end
        1: rpi_write($urandom_range(0, CH - 1), 8'($urandom));
        2: rpi_read($urandom_range(0, CH - 1));
        default: begin
          if ($urandom_range(0, 3) == 0) ti_read_check(16'($urandom_range(16'h4000, 16'h5FFF)));
          else                           ti_read_check(addr_list[$urandom_range(0, 9)]);
        end
      endcase
    end
    cru_dsr_en = 1'b1;

    // Reset in the middle of a shift-out, with no clock edge before the check.
    ti_write(16'h5FFF, 8'hA5);
    rpi_latch(CH);
    flag_m[0] = 1'b0;
    ti_write(16'h5FFD, 8'h5A);
    sclk_pulse();
    sclk_pulse();
    push(K_SDO, 8'h01);
    push(K_IRQ, 8'h01);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    push(K_SDO, 8'h00);
    push(K_IRQ, 8'h00);
    drain();
    step(1);
    rst_n = 1'b1;
    step(3);
    ti_read_check(16'h5FFB);
    ti_read_check(16'h5FF9);
    rpi_read(0);
    rpi_read(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
